// File: rtl/writeback_regfile_if.sv
// EX->WB pipeline register and register-file read ports between alu_stage, decode and writeback.
// The upstream side uses master; writeback_regfile uses slave.
interface writeback_regfile_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
);
    typedef struct packed {
        logic [XLEN-1:0] alu_result;
        logic            alu_result_ready;
        logic [AW-1:0]   reg_wr_addr;
        logic            reg_wr_en;
    } ex_wb_t;

    ex_wb_t          ex_wb_reg;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] alu_reg_input_a;
    logic [XLEN-1:0] alu_reg_input_b;

    modport master (
        output ex_wb_reg, rs1_addr, rs2_addr,
        input  alu_reg_input_a, alu_reg_input_b
    );

    modport slave (
        input  ex_wb_reg, rs1_addr, rs2_addr,
        output alu_reg_input_a, alu_reg_input_b
    );
endinterface

// File: rtl/writeback_regfile.sv
// Writeback stage and integer register file: commits EX_WB results to x1..x31,
// serves two bypassed read ports plus a raw debug port, and counts retired ops.
module writeback_regfile #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned INSTRET_W = 64,
    localparam int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    writeback_regfile_if.slave   wb,
    input  logic [AW-1:0]        dbg_addr,
    output logic [XLEN-1:0]      dbg_data,
    output logic [INSTRET_W-1:0] instret,
    output logic                 wb_commit,
    output logic [AW-1:0]        wb_commit_addr
);
    logic [XLEN-1:0] regs [NUM_REGS];
    logic            we;
    logic            ready;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;

    assign ready   = wb.ex_wb_reg.alu_result_ready;
    assign wr_addr = wb.ex_wb_reg.reg_wr_addr;
    assign wr_data = wb.ex_wb_reg.alu_result;

    // Gating with reset_n keeps the bypass from leaking a pending write while reset is held.
    assign we = ready & wb.ex_wb_reg.reg_wr_en & (wr_addr != '0) & reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instret        <= '0;
            wb_commit      <= 1'b0;
            wb_commit_addr <= '0;
        end else begin
            if (ready) begin
                instret <= instret + INSTRET_W'(1);
            end
            wb_commit <= we;
            if (we) begin
                wb_commit_addr <= wr_addr;
            end
        end
    end

    // Read priority: x0, then same-cycle write-through, then the array.
    always_comb begin
        wb.alu_reg_input_a = regs[wb.rs1_addr];
        if (wb.rs1_addr == '0) begin
            wb.alu_reg_input_a = '0;
        end else if (we && (wb.rs1_addr == wr_addr)) begin
            wb.alu_reg_input_a = wr_data;
        end
    end

    always_comb begin
        wb.alu_reg_input_b = regs[wb.rs2_addr];
        if (wb.rs2_addr == '0) begin
            wb.alu_reg_input_b = '0;
        end else if (we && (wb.rs2_addr == wr_addr)) begin
            wb.alu_reg_input_b = wr_data;
        end
    end

    assign dbg_data = regs[dbg_addr];
endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: a 64-bit instret build plus a 4-bit
// instret build driven in lockstep so counter wrap is reachable quickly.
module tb_writeback_regfile;
    logic clk = 1'b0;
    logic reset_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    writeback_regfile_if #(.XLEN(32), .AW(5)) bus  ();
    writeback_regfile_if #(.XLEN(32), .AW(5)) bus4 ();

    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data, dbg_data4;
    logic [63:0] instret;
    logic [3:0]  instret4;
    logic        wb_commit, wb_commit4;
    logic [4:0]  wb_commit_addr, wb_commit_addr4;

    writeback_regfile #(.XLEN(32), .NUM_REGS(32), .INSTRET_W(64)) dut (
        .clk(clk), .reset_n(reset_n), .wb(bus.slave),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .instret(instret),
        .wb_commit(wb_commit), .wb_commit_addr(wb_commit_addr)
    );

    writeback_regfile #(.XLEN(32), .NUM_REGS(32), .INSTRET_W(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .wb(bus4.slave),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data4), .instret(instret4),
        .wb_commit(wb_commit4), .wb_commit_addr(wb_commit_addr4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic en, input logic [4:0] wa, input logic [31:0] res);
        bus.ex_wb_reg.alu_result        = res;
        bus.ex_wb_reg.alu_result_ready  = rdy;
        bus.ex_wb_reg.reg_wr_addr       = wa;
        bus.ex_wb_reg.reg_wr_en         = en;
        bus4.ex_wb_reg.alu_result       = res;
        bus4.ex_wb_reg.alu_result_ready = rdy;
        bus4.ex_wb_reg.reg_wr_addr      = wa;
        bus4.ex_wb_reg.reg_wr_en        = en;
    endtask

    task automatic rd(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
        bus.rs1_addr  = a;
        bus.rs2_addr  = b;
        bus4.rs1_addr = a;
        bus4.rs2_addr = b;
        dbg_addr      = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        rd(5'd0, 5'd0, 5'd0);
        tick();
        tick();
        chk("rst_instret", instret, 64'd0);
        chk("rst_commit", {63'd0, wb_commit}, 64'd0);
        chk("rst_commit_addr", {59'd0, wb_commit_addr}, 64'd0);
        #3 reset_n = 1'b1;
        tick();

        // All addresses read zero on every port after reset.
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(i), 5'(i));
            #1;
            chk("rst_rd_a", {32'd0, bus.alu_reg_input_a}, 64'd0);
            chk("rst_rd_b", {32'd0, bus.alu_reg_input_b}, 64'd0);
            chk("rst_rd_dbg", {32'd0, dbg_data}, 64'd0);
        end
        chk("rst_instret4", {60'd0, instret4}, 64'd0);

        // Write x5 with same-cycle bypass on port A.
        drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF);
        rd(5'd5, 5'd0, 5'd5);
        #1;
        chk("byp_a_x5", {32'd0, bus.alu_reg_input_a}, 64'hDEADBEEF);
        chk("byp_b_x0", {32'd0, bus.alu_reg_input_b}, 64'd0);
        chk("dbg_no_byp", {32'd0, dbg_data}, 64'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("dbg_x5", {32'd0, dbg_data}, 64'hDEADBEEF);
        chk("commit_x5", {63'd0, wb_commit}, 64'd1);
        chk("commit_addr_x5", {59'd0, wb_commit_addr}, 64'd5);
        chk("instret_1", instret, 64'd1);

        // Write to x0 is dropped but still retires.
        drive(1'b1, 1'b1, 5'd0, 32'h12345678);
        rd(5'd0, 5'd0, 5'd0);
        #1;
        chk("x0_byp_a", {32'd0, bus.alu_reg_input_a}, 64'd0);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("x0_dbg", {32'd0, dbg_data}, 64'd0);
        chk("x0_commit", {63'd0, wb_commit}, 64'd0);
        chk("x0_commit_addr_hold", {59'd0, wb_commit_addr}, 64'd5);
        chk("instret_2", instret, 64'd2);

        // Stale EX_WB (ready=0) is neither written nor forwarded.
        drive(1'b1, 1'b1, 5'd7, 32'h11111111);
        tick();
        drive(1'b0, 1'b1, 5'd7, 32'hFFFFFFFF);
        rd(5'd0, 5'd7, 5'd7);
        #1;
        chk("stale_b_x7", {32'd0, bus.alu_reg_input_b}, 64'h11111111);
        tick();
        chk("stale_dbg_x7", {32'd0, dbg_data}, 64'h11111111);
        chk("stale_instret", instret, 64'd3);
        chk("stale_commit", {63'd0, wb_commit}, 64'd0);
        chk("stale_commit_addr", {59'd0, wb_commit_addr}, 64'd7);

        // Both ports bypass the same register; back-to-back writes keep the last.
        drive(1'b1, 1'b1, 5'd9, 32'hA5A5A5A5);
        rd(5'd9, 5'd9, 5'd9);
        #1;
        chk("dual_byp_a", {32'd0, bus.alu_reg_input_a}, 64'hA5A5A5A5);
        chk("dual_byp_b", {32'd0, bus.alu_reg_input_b}, 64'hA5A5A5A5);
        tick();
        drive(1'b1, 1'b1, 5'd9, 32'h1);
        tick();
        drive(1'b1, 1'b1, 5'd9, 32'h2);
        #1;
        chk("b2b_byp_b", {32'd0, bus.alu_reg_input_b}, 64'h2);
        chk("b2b_dbg_prev", {32'd0, dbg_data}, 64'h1);
        tick();
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("b2b_dbg_x9", {32'd0, dbg_data}, 64'h2);
        chk("b2b_arr_a", {32'd0, bus.alu_reg_input_a}, 64'h2);
        chk("instret_6", instret, 64'd6);
        chk("instret4_6", {60'd0, instret4}, 64'd6);

        // Retire non-writing ops up to 15, then wrap the 4-bit counter.
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b0, 5'd3, 32'h0);
            tick();
        end
        chk("instret4_15", {60'd0, instret4}, 64'd15);
        chk("instret_15", instret, 64'd15);
        chk("nowr_commit", {63'd0, wb_commit}, 64'd0);
        tick();
        chk("instret4_wrap", {60'd0, instret4}, 64'd0);
        chk("instret_16", instret, 64'd16);

        // Async reset mid-burst with a write to x3 pending.
        drive(1'b1, 1'b1, 5'd3, 32'h0000CAFE);
        rd(5'd3, 5'd9, 5'd3);
        tick();
        tick();
        chk("burst_dbg_x3", {32'd0, dbg_data}, 64'h0000CAFE);
        chk("burst_instret", instret, 64'd18);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_a_x3", {32'd0, bus.alu_reg_input_a}, 64'd0);
        chk("arst_b_x9", {32'd0, bus.alu_reg_input_b}, 64'd0);
        chk("arst_dbg_x3", {32'd0, dbg_data}, 64'd0);
        chk("arst_instret", instret, 64'd0);
        chk("arst_instret4", {60'd0, instret4}, 64'd0);
        chk("arst_commit", {63'd0, wb_commit}, 64'd0);
        chk("arst_commit_addr", {59'd0, wb_commit_addr}, 64'd0);
        tick();
        chk("arst_hold_dbg", {32'd0, dbg_data}, 64'd0);
        chk("arst_hold_instret", instret, 64'd0);
        drive(1'b0, 1'b0, 5'd0, 32'h0);
        #2 reset_n = 1'b1;
        tick();
        chk("post_rst_dbg", {32'd0, dbg_data}, 64'd0);
        chk("post_rst_instret", instret, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
